data_mem_rmw: RTL and testbench
===============================

# data_mem_rmw

Word-organised data memory for the MEM stage of the pipelined MIPS datapath, sitting directly upstream of the halfword/byte load-extract logic. It returns the full aligned 32-bit word for every load as `MemData`. Sub-word extraction is left to the downstream stage. It implements `sw`, `sh` and `sb` on a single-port, word-wide array with no byte enables, so sub-word stores run as a two-cycle read-modify-write sequence that stalls the pipeline for one cycle.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words; must be a power of two.
- `ADDR_W`, 10: word-index width, equal to log2(`DEPTH`).

Ports:
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  load request this cycle.
- `MemWrite`  in  1  store request this cycle.
- `StoreSize`  in  2  store width: 00 word, 01 halfword, 10 byte, 11 reserved (store suppressed).
- `Address`  in  32  byte address from the ALU.
- `WriteData`  in  32  store data, right-justified for `sh` and `sb`.
- `MemData`  out  32  registered aligned word read from `Address[ADDR_W+1:2]`.
- `Stall`  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers this cycle.
- `Misaligned`  out  1  combinational flag for the current access; the store is suppressed.

## Operation
- Word index is `Address[ADDR_W+1:2]`. Upper address bits are ignored, so addresses alias modulo `DEPTH` words.
- Misaligned: `MemWrite` asserted with word size and `Address[1:0]` != 0, or halfword size and `Address[0]` = 1, or `StoreSize` = 11.
  - A misaligned store writes nothing and takes no RMW cycle.
  - Loads are never flagged; they always return the aligned word.
- FSM states: IDLE and MERGE.
- IDLE:
  - Word store, aligned: the array word is written at the edge. Stay in IDLE.
  - Halfword or byte store, aligned: `Stall` = 1 combinationally. The merge register captures the array word at the edge. Go to MERGE.
  - `MemRead` with no store: `MemData` is loaded with the array word at the edge.
  - `MemRead` and `MemWrite` both asserted: the store wins and `MemData` holds its value.
- MERGE:
  - `Stall` = 0. Inputs are still held from the stalled cycle.
  - Halfword store: `WriteData[15:0]` replaces bits [15:0] when `Address[1]` = 0, or bits [31:16] when `Address[1]` = 1.
  - Byte store: `WriteData[7:0]` replaces byte `Address[1:0]`, where byte 0 is bits [7:0].
  - The merged word is written at the edge, then the FSM returns to IDLE.
  - `MemRead` is ignored and `MemData` holds.
- Reset:
  - `MemData` = 0, `Stall` = 0, state = IDLE, merge register = 0.
  - Array contents are not cleared.
  - Reset asserted in MERGE aborts the sequence; no write occurs.

## Timing
- Load latency is 1 cycle. `MemRead` sampled at edge N gives valid `MemData` after edge N, which the MEM/WB register captures at edge N+1.
- A word store takes 1 cycle. A sub-word store takes 2 cycles, with exactly one `Stall` cycle.
- `Stall` is combinational from `MemWrite`, `StoreSize`, `Address` and state. It is never high for two consecutive cycles from one store.
- Read-after-write: a load issued the cycle after a store completes returns the new word. There is no bypass within the same cycle.
- Back-to-back sub-word stores each pay 1 stall cycle: the IDLE, MERGE, IDLE, MERGE sequence gives a `Stall` pattern of 1, 0, 1, 0.
- `Misaligned` is valid in the same cycle as the request and is never registered.

## Test plan
- Reset, then `sw` 0xDEADBEEF to 0x10, then `lw` 0x10 -> `MemData` = 0xDEADBEEF one cycle after the request; `MemData` = 0 immediately after reset.
- Word 0x10 holding 0xDEADBEEF, then `sh` 0x1234 to 0x12 -> `Stall` high for exactly 1 cycle; subsequent `lw` 0x10 returns 0x1234BEEF. Repeat `sh` 0xAAAA to 0x10 -> 0x1234AAAA.
- Word 0x20 holding 0x00000000, then `sb` 0x11, 0x22, 0x33, 0x44 to 0x20–0x23 back-to-back -> `Stall` pattern 1,0,1,0,1,0,1,0; `lw` 0x20 returns 0x44332211.
- `sw` to 0x13 and `sh` to 0x11 -> `Misaligned` = 1, `Stall` = 0, word 0x10 unchanged on a following `lw`.
- Reset asserted in the MERGE cycle of `sb` 0xFF to 0x30, with word 0x30 holding 0x01020304 -> no write; after reset release, `lw` 0x30 returns 0x01020304 and `MemData` was 0 during reset.
- `sw` 0x55 to byte address 0x1000 with `DEPTH` = 1024 -> `lw` 0x0 returns 0x55 (index wraparound).

Source files
------------

// File: rtl/data_mem_rmw.sv
// Word-wide MEM-stage data memory for the MIPS pipeline.
// Sub-word stores take a read-modify-write pass and stall the pipe for one cycle.
module data_mem_rmw #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  StoreSize,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] MemData,
    output logic        Stall,
    output logic        Misaligned
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_mem [DEPTH];
    logic [31:0]        r_merge;
    logic [31:0]        r_data;
    logic [31:0]        w_merged;
    logic [31:0]        w_wdata;
    logic               w_we;
    logic               w_cap;
    logic [ADDR_W-1:0]  w_idx;

    assign w_idx   = Address[ADDR_W+1:2];
    assign MemData = r_data;

    assign Misaligned = MemWrite &&
        ((StoreSize == 2'b11) ||
         (StoreSize == 2'b00 && Address[1:0] != 2'b00) ||
         (StoreSize == 2'b01 && Address[0]));

    // Insert the right-justified store data into the captured word
    always_comb begin
        w_merged = r_merge;
        if (StoreSize == 2'b01) begin
            if (Address[1]) w_merged[31:16] = WriteData[15:0];
            else            w_merged[15:0]  = WriteData[15:0];
        end else begin
            case (Address[1:0])
                2'd0:    w_merged[7:0]   = WriteData[7:0];
                2'd1:    w_merged[15:8]  = WriteData[7:0];
                2'd2:    w_merged[23:16] = WriteData[7:0];
                default: w_merged[31:24] = WriteData[7:0];
            endcase
        end
    end

    always_comb begin
        w_next  = r_state;
        Stall   = 1'b0;
        w_we    = 1'b0;
        w_cap   = 1'b0;
        w_wdata = WriteData;
        case (r_state)
            IDLE: begin
                if (MemWrite && !Misaligned) begin
                    if (StoreSize == 2'b00) begin
                        w_we = 1'b1;
                    end else begin
                        Stall  = 1'b1;
                        w_cap  = 1'b1;
                        w_next = MERGE;
                    end
                end
            end
            MERGE: begin
                w_we    = 1'b1;
                w_wdata = w_merged;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_merge <= 32'h0;
            r_data  <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_cap)
                r_merge <= r_mem[w_idx];
            if (r_state == IDLE && MemRead && !MemWrite)
                r_data <= r_mem[w_idx];
        end
    end

    // Array is never cleared; reset only blocks a pending write
    always_ff @(posedge Clk) begin
        if (w_we && !Reset)
            r_mem[w_idx] <= w_wdata;
    end

endmodule

// File: tb/tb_data_mem_rmw.sv
// Scoreboard bench for data_mem_rmw: directed cases then random
// loads/stores against a word-array reference model.
module tb_data_mem_rmw;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  StoreSize;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] MemData;
    logic        Stall;
    logic        Misaligned;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mdl [1024];
    logic [31:0] exp_q [$];

    data_mem_rmw #(.DEPTH(1024), .ADDR_W(10)) dut (
        .Clk(Clk), .Reset(Reset), .MemRead(MemRead),
        .MemWrite(MemWrite), .StoreSize(StoreSize),
        .Address(Address), .WriteData(WriteData),
        .MemData(MemData), .Stall(Stall), .Misaligned(Misaligned)
    );

    always #5 Clk = ~Clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic bit mis_f(int sz, logic [31:0] a);
        if (sz == 3) return 1'b1;
        if (sz == 0) return (a % 4) != 0;
        if (sz == 1) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic int idx_f(logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    // Reference: replace the addressed lane(s) of the stored word
    task automatic mdl_store(int sz, logic [31:0] a, logic [31:0] d);
        int i;
        int sh;
        logic [31:0] m;
        i = idx_f(a);
        if (sz == 0) begin
            mdl[i] = d;
        end else begin
            sh = 8 * int'(a % 4);
            m  = (sz == 1) ? 32'hFFFF : 32'hFF;
            mdl[i] = (mdl[i] & ~(m << sh)) | ((d & m) << sh);
        end
    endtask

    always @(posedge Clk) begin : monitor
        logic s;
        logic [31:0] e;
        s = MemRead && !MemWrite && !Reset;
        #1;
        if (s) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL load_unexpected: got %h expected none", MemData);
            end else begin
                e = exp_q.pop_front();
                chk("load_data", MemData, e);
            end
        end
    end

    task automatic idle();
        @(negedge Clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic do_store(int sz, logic [31:0] a, logic [31:0] d, bit rd);
        bit m;
        bit sub;
        @(negedge Clk);
        MemWrite  = 1'b1;
        MemRead   = rd;
        StoreSize = 2'(sz);
        Address   = a;
        WriteData = d;
        m   = mis_f(sz, a);
        sub = !m && (sz == 1 || sz == 2);
        #1;
        chk("misaligned", {31'b0, Misaligned}, {31'b0, m});
        chk("stall_issue", {31'b0, Stall}, {31'b0, sub});
        @(posedge Clk);
        if (sub) begin
            @(negedge Clk);
            #1;
            chk("stall_merge", {31'b0, Stall}, 32'h0);
            @(posedge Clk);
        end
        if (!m) mdl_store(sz, a, d);
    endtask

    task automatic do_load(logic [31:0] a);
        @(negedge Clk);
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        Address  = a;
        exp_q.push_back(mdl[idx_f(a)]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] hold;
        int sz;
        Reset = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        StoreSize = 2'b00;
        Address = 32'h0;
        WriteData = 32'h0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_memdata", MemData, 32'h0);
        chk("reset_stall", {31'b0, Stall}, 32'h0);
        Reset = 1'b0;

        do_store(0, 32'h10, 32'hDEADBEEF, 0);
        do_load(32'h10);
        do_store(1, 32'h12, 32'h1234, 0);
        do_load(32'h10);
        chk("sh_hi_model", mdl[4], 32'h1234BEEF);
        do_store(1, 32'h10, 32'hAAAA, 0);
        do_load(32'h10);

        do_store(0, 32'h20, 32'h0, 0);
        do_store(2, 32'h20, 32'h11, 0);
        do_store(2, 32'h21, 32'h22, 0);
        do_store(2, 32'h22, 32'h33, 0);
        do_store(2, 32'h23, 32'h44, 0);
        do_load(32'h20);
        chk("sb_model", mdl[8], 32'h44332211);

        do_store(0, 32'h13, 32'hFFFFFFFF, 0);
        do_store(1, 32'h11, 32'hFFFF, 0);
        do_store(3, 32'h10, 32'hFFFFFFFF, 0);
        do_load(32'h10);

        // Reset during the merge cycle must leave the word intact
        do_store(0, 32'h30, 32'h01020304, 0);
        @(negedge Clk);
        MemWrite = 1'b1;
        MemRead = 1'b0;
        StoreSize = 2'b10;
        Address = 32'h30;
        WriteData = 32'hFF;
        #1;
        chk("rst_merge_stall", {31'b0, Stall}, 32'h1);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("rst_merge_memdata", MemData, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        MemWrite = 1'b0;
        do_load(32'h30);

        do_store(0, 32'h1000, 32'h55, 0);
        do_load(32'h0);

        // Both strobes: store wins and MemData must not change
        idle();
        hold = MemData;
        do_store(0, 32'h40, 32'hCAFEF00D, 1);
        #1;
        chk("rw_hold", MemData, hold);

        for (int i = 0; i < 16; i++)
            do_store(0, 32'h100 + 32'(4 * i), $urandom, 0);
        for (int i = 0; i < 300; i++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'h100 | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 2) == 0) begin
                do_load(a);
            end else begin
                sz = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
                do_store(sz, a, $urandom, 0);
            end
        end
        for (int i = 0; i < 16; i++)
            do_load(32'h100 + 32'(4 * i));
        idle();
        repeat (3) @(posedge Clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
